wt_dcache_ld_ctrl: RTL

Load-port controller for the write-through L1 data cache. It sits directly upstream of the dcache memory/arbiter block and drives one of its read ports. It accepts one load at a time from the LSU and issues the index/offset read. It presents the tag one cycle after the read is granted, then evaluates hit/miss. On a miss or a noncacheable access it issues a miss request; cacheable refills are replayed through the read port.

---
 rtl/wt_cache_pkg.sv | 30 +++
 rtl/wt_dcache_ld_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache types and geometry.
// Holds the cache slicing widths, the load-controller state type and the
// registered load-request payload used by wt_dcache_ld_ctrl.
package wt_cache_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_SET_ASSOC    = 8;
  localparam int unsigned DCACHE_PADDR_WIDTH  = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_READ,
    LD_TAGCMP,
    LD_MISS_REQ,
    LD_MISS_WAIT,
    LD_KILL_WAIT,
    LD_REPLAY
  } ld_ctrl_state_e;

  // Load captured on accept; stays stable for the whole transaction.
  typedef struct packed {
    logic [DCACHE_PADDR_WIDTH-1:0] paddr;
    logic [1:0]                    size;
    logic                          nc;
  } ld_req_t;

endpackage

// File: rtl/wt_dcache_ld_ctrl.sv
// Load-port controller for the write-through L1 data cache.
// Accepts one LSU load at a time, drives a dcache read port (index/offset,
// then tag one cycle after grant), evaluates hit/miss and raises a miss
// request on a miss or noncacheable access. Cacheable refills are replayed
// through the read port.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_*                     LSU load request (valid/ready, paddr, size, nc)
//   kill_i                    abort current load, no response
//   rsp_valid_o, rsp_data_o   one-cycle load response
//   rd_*                      dcache read port
//   miss_*                    miss unit request / return
module wt_dcache_ld_ctrl
  import wt_cache_pkg::*;
#(
  parameter logic [2:0] MissSize = 3'b011
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [DCACHE_PADDR_WIDTH-1:0]  req_paddr_i,
  input  logic [1:0]                     req_size_i,
  input  logic                           req_nc_i,
  input  logic                           kill_i,
  output logic                           rsp_valid_o,
  output logic [63:0]                    rsp_data_o,
  output logic                           rd_req_o,
  input  logic                           rd_ack_i,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
  output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
  output logic                           rd_tag_only_o,
  output logic                           rd_prio_o,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i,
  input  logic [63:0]                    rd_data_i,
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  output logic [63:0]                    miss_paddr_o,
  output logic [2:0]                     miss_size_o,
  output logic                           miss_nc_o,
  input  logic                           miss_rtrn_vld_i,
  input  logic [63:0]                    miss_rtrn_data_i
);

  ld_ctrl_state_e state_q, state_d;
  ld_req_t        req_q;
  logic           accept;

  // State and captured request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LD_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{paddr: req_paddr_i, size: req_size_i, nc: req_nc_i};
      end
    end
  end

  // Next state and port outputs.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_data_o    = '0;
    rd_req_o      = 1'b0;
    rd_tag_only_o = 1'b0;
    rd_prio_o     = 1'b0;
    miss_req_o    = 1'b0;
    rd_idx_o      = req_q.paddr[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
    rd_off_o      = req_q.paddr[DCACHE_OFFSET_WIDTH-1:0];
    rd_tag_o      = req_q.paddr[DCACHE_PADDR_WIDTH-1:DCACHE_INDEX_WIDTH];
    miss_paddr_o  = 64'(req_q.paddr);
    miss_size_o   = req_q.nc ? {1'b0, req_q.size} : MissSize;
    miss_nc_o     = req_q.nc;

    case (state_q)
      LD_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = req_nc_i ? LD_MISS_REQ : LD_READ;
        end
      end
      LD_READ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          state_d = LD_IDLE;
        end else if (rd_ack_i) begin
          state_d = LD_TAGCMP;
        end
      end
      LD_TAGCMP: begin
        // Kill wins over a hit: the load is dropped silently.
        if (kill_i) begin
          state_d = LD_IDLE;
        end else if (|rd_hit_oh_i) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = rd_data_i;
          state_d     = LD_IDLE;
        end else begin
          state_d = LD_MISS_REQ;
        end
      end
      LD_MISS_REQ: begin
        miss_req_o = 1'b1;
        // Once acked the miss is outstanding and its return must be drained.
        if (miss_ack_i) begin
          state_d = kill_i ? LD_KILL_WAIT : LD_MISS_WAIT;
        end else if (kill_i) begin
          state_d = LD_IDLE;
        end
      end
      LD_MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          if (kill_i) begin
            state_d = LD_IDLE;
          end else if (req_q.nc) begin
            rsp_valid_o = 1'b1;
            rsp_data_o  = miss_rtrn_data_i;
            state_d     = LD_IDLE;
          end else begin
            state_d = LD_REPLAY;
          end
        end else if (kill_i) begin
          state_d = LD_KILL_WAIT;
        end
      end
      LD_KILL_WAIT: begin
        if (miss_rtrn_vld_i) begin
          state_d = LD_IDLE;
        end
      end
      LD_REPLAY: begin
        state_d = kill_i ? LD_IDLE : LD_READ;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase

    // Everything reads as zero while reset is held.
    if (rst_i) begin
      accept        = 1'b0;
      req_ready_o   = 1'b0;
      rsp_valid_o   = 1'b0;
      rsp_data_o    = '0;
      rd_req_o      = 1'b0;
      rd_idx_o      = '0;
      rd_off_o      = '0;
      rd_tag_o      = '0;
      miss_req_o    = 1'b0;
      miss_paddr_o  = '0;
      miss_size_o   = '0;
      miss_nc_o     = 1'b0;
    end
  end

endmodule
